digit_value_counter: RTL and testbench

//   Upstream value source for the two-digit decimal 7-segment display stage.

---
 rtl/digit_value_counter_pkg.sv | 14 +
 rtl/digit_value_counter_debouncer.sv | 65 ++++++
 rtl/digit_value_counter.sv | 73 +++++++
 tb/tb_digit_value_counter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/digit_value_counter_pkg.sv
// digit_value_counter_pkg: debouncer state encoding and the modulo-16 step helper.
package digit_value_counter_pkg;
   typedef enum logic [1:0] {
      DB_RELEASED,
      DB_PRESS_WAIT,
      DB_PRESSED,
      DB_RELEASE_WAIT
   } db_state_t;
   // Returns {wrap, next}; up and down together cancel out.
   function automatic logic [4:0] step_value(input logic [3:0] v, input logic up, input logic dn);
      return (up && !dn) ? {v == 4'd15, v + 4'd1} :
             (dn && !up) ? {v == 4'd0, v - 4'd1} : {1'b0, v};
   endfunction
endpackage

// File: rtl/digit_value_counter_debouncer.sv
// key_debouncer: 2-FF synchronizer plus press/release settle FSM, one pulse per press.
module key_debouncer
   import digit_value_counter_pkg::*;
#(
   parameter int DB_CYCLES = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_press
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] TC = CW'(DB_CYCLES - 1);
   logic            r_meta;
   logic            r_sync;
   logic [CW-1:0]   r_cnt;
   logic            r_press;
   db_state_t       r_state;
   assign o_press = r_press;
   // The edge that leaves a stable state already counts as the first settled sample.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta  <= 1'b1;
         r_sync  <= 1'b1;
         r_state <= DB_RELEASED;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_meta  <= i_key_n;
         r_sync  <= r_meta;
         r_press <= 1'b0;
         case (r_state)
            DB_RELEASED:
               if (!r_sync) begin
                  r_state <= DB_PRESS_WAIT;
                  r_cnt   <= CW'(1);
               end
            DB_PRESS_WAIT:
               if (r_sync) begin
                  r_state <= DB_RELEASED;
                  r_cnt   <= '0;
               end else if (r_cnt >= TC) begin
                  r_state <= DB_PRESSED;
                  r_press <= 1'b1;
                  r_cnt   <= '0;
               end else
                  r_cnt <= r_cnt + CW'(1);
            DB_PRESSED:
               if (r_sync) begin
                  r_state <= DB_RELEASE_WAIT;
                  r_cnt   <= CW'(1);
               end
            DB_RELEASE_WAIT:
               if (!r_sync) begin
                  r_state <= DB_PRESSED;
                  r_cnt   <= '0;
               end else if (r_cnt >= TC) begin
                  r_state <= DB_RELEASED;
                  r_cnt   <= '0;
               end else
                  r_cnt <= r_cnt + CW'(1);
         endcase
      end
   end
endmodule

// File: rtl/digit_value_counter.sv
// digit_value_counter: 4-bit value from debounced keys, auto-increment prescaler or switch load.
module digit_value_counter
   import digit_value_counter_pkg::*;
#(
   parameter int CLK_HZ      = 50_000_000,
   parameter int DEBOUNCE_MS = 10,
   parameter int AUTO_HZ     = 1
) (
   input  logic       CLOCK_50,
   input  logic       RST_N,
   input  logic       KEY_UP_N,
   input  logic       KEY_DN_N,
   input  logic       SW_AUTO,
   input  logic       SW_LOAD,
   input  logic [3:0] SW_VAL,
   output logic [3:0] VALUE,
   output logic       WRAP
);
   localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int AUTO_DIV  = CLK_HZ / AUTO_HZ;
   localparam int PW        = $clog2(AUTO_DIV + 1);
   localparam logic [PW-1:0] PRE_TC = PW'(AUTO_DIV - 1);
   logic          r_rst_meta;
   logic          r_rst_n;
   logic [5:0]    r_sw_meta;
   logic [5:0]    r_sw;
   logic [PW-1:0] r_pre;
   logic [3:0]    r_value;
   logic          r_wrap;
   logic          w_up;
   logic          w_dn;
   logic          w_auto;
   logic          w_load;
   logic [3:0]    w_val;
   assign {w_auto, w_load, w_val} = r_sw;
   assign VALUE = r_value;
   assign WRAP  = r_wrap;
   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) {r_rst_n, r_rst_meta} <= 2'b00;
      else        {r_rst_n, r_rst_meta} <= {r_rst_meta, 1'b1};
   end
   key_debouncer #(.DB_CYCLES(DB_CYCLES)) u_up (
      .i_clk(CLOCK_50), .i_rst_n(r_rst_n), .i_key_n(KEY_UP_N), .o_press(w_up));
   key_debouncer #(.DB_CYCLES(DB_CYCLES)) u_dn (
      .i_clk(CLOCK_50), .i_rst_n(r_rst_n), .i_key_n(KEY_DN_N), .o_press(w_dn));
   always_ff @(posedge CLOCK_50 or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_sw_meta <= '0;
         r_sw      <= '0;
         r_pre     <= '0;
         r_value   <= '0;
         r_wrap    <= 1'b0;
      end else begin
         r_sw_meta <= {SW_AUTO, SW_LOAD, SW_VAL};
         r_sw      <= r_sw_meta;
         r_wrap    <= 1'b0;
         if (w_load) begin
            r_value <= w_val;
            r_pre   <= '0;
         end else if (w_auto) begin
            if (r_pre == PRE_TC) begin
               {r_wrap, r_value} <= step_value(r_value, 1'b1, 1'b0);
               r_pre <= '0;
            end else
               r_pre <= r_pre + PW'(1);
         end else begin
            r_pre <= '0;
            {r_wrap, r_value} <= step_value(r_value, w_up, w_dn);
         end
      end
   end
endmodule

// File: tb/tb_digit_value_counter.sv
// tb_digit_value_counter: directed vectors for keys, debounce latency, auto mode, load and reset.
module tb_digit_value_counter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       up_n = 1'b1;
   logic       dn_n = 1'b1;
   logic       sw_auto = 1'b0;
   logic       sw_load = 1'b0;
   logic [3:0] sw_val = 4'd0;
   logic [3:0] value;
   logic       wrap;
   int         checks = 0;
   int         errors = 0;
   always #5 clk = ~clk;
   digit_value_counter #(.CLK_HZ(1000), .DEBOUNCE_MS(3), .AUTO_HZ(100)) dut (
      .CLOCK_50(clk), .RST_N(rst_n), .KEY_UP_N(up_n), .KEY_DN_N(dn_n),
      .SW_AUTO(sw_auto), .SW_LOAD(sw_load), .SW_VAL(sw_val),
      .VALUE(value), .WRAP(wrap));
   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   // Press lands on VALUE 2 sync + 3 settle + 1 register = 6 edges after the drive.
   task automatic key_step(input string tag, input logic up, input logic dn,
                           input logic [3:0] pv, input logic [3:0] ev, input logic ew);
      up_n = ~up;
      dn_n = ~dn;
      tick(5);
      chk({tag, "_before"}, value, pv);
      tick(1);
      chk(tag, value, ev);
      chk({tag, "_wrap"}, {3'b0, wrap}, {3'b0, ew});
      tick(1);
      chk({tag, "_wrap_end"}, {3'b0, wrap}, 4'd0);
      up_n = 1'b1;
      dn_n = 1'b1;
      tick(8);
   endtask
   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(3);
      chk("reset_value", value, 4'd0);
      chk("reset_wrap", {3'b0, wrap}, 4'd0);
      up_n = 1'b0; tick(1);
      up_n = 1'b1; tick(1);
      up_n = 1'b0; tick(1);
      up_n = 1'b1; tick(1);
      up_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("bounce_wait", value, 4'd0);
      end
      tick(1);
      chk("bounce_step", value, 4'd1);
      tick(20);
      chk("hold", value, 4'd1);
      up_n = 1'b1;
      tick(8);
      chk("release", value, 4'd1);
      key_step("dn_1_to_0", 1'b0, 1'b1, 4'd1, 4'd0, 1'b0);
      key_step("dn_wrap", 1'b0, 1'b1, 4'd0, 4'd15, 1'b1);
      key_step("both_keys", 1'b1, 1'b1, 4'd15, 4'd15, 1'b0);
      key_step("up_wrap", 1'b1, 1'b0, 4'd15, 4'd0, 1'b1);
      sw_val = 4'd14;
      sw_load = 1'b1;
      tick(2);
      chk("load14_sync", value, 4'd0);
      tick(1);
      chk("load14", value, 4'd14);
      sw_load = 1'b0;
      sw_auto = 1'b1;
      up_n = 1'b0;
      tick(8);
      chk("auto_key_ignored", value, 4'd14);
      tick(3);
      chk("auto_pre15", value, 4'd14);
      tick(1);
      chk("auto_15", value, 4'd15);
      chk("auto_15_wrap", {3'b0, wrap}, 4'd0);
      tick(9);
      chk("auto_pre0", value, 4'd15);
      tick(1);
      chk("auto_0", value, 4'd0);
      chk("auto_0_wrap", {3'b0, wrap}, 4'd1);
      up_n = 1'b1;
      sw_val = 4'd9;
      sw_load = 1'b1;
      tick(1);
      chk("auto_wrap_end", {3'b0, wrap}, 4'd0);
      tick(1);
      chk("load9_sync", value, 4'd0);
      tick(1);
      chk("load9", value, 4'd9);
      sw_auto = 1'b0;
      up_n = 1'b0;
      tick(8);
      chk("load_blocks_up", value, 4'd9);
      up_n = 1'b1;
      tick(6);
      sw_auto = 1'b1;
      tick(4);
      chk("load_blocks_auto", value, 4'd9);
      sw_load = 1'b0;
      tick(11);
      chk("after_load_wait", value, 4'd9);
      tick(1);
      chk("after_load_step", value, 4'd10);
      tick(5);
      sw_auto = 1'b0;
      tick(20);
      chk("manual_no_step", value, 4'd10);
      sw_auto = 1'b1;
      tick(11);
      chk("prescaler_cleared", value, 4'd10);
      tick(1);
      chk("auto_resume", value, 4'd11);
      sw_auto = 1'b0;
      tick(3);
      up_n = 1'b0;
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_value", value, 4'd0);
      chk("async_reset_wrap", {3'b0, wrap}, 4'd0);
      up_n = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(12);
      chk("no_pulse_after_reset", value, 4'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
